mult_ctrl: RTL
==============

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, product width; N even, N >= 4.
REQ-002 SHALL define W = N/2 internally as the operand width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 clear_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a multiply; sampled only in IDLE.
REQ-006 a  input  W  multiplicand, unsigned.
REQ-007 b  input  W  multiplier, unsigned.
REQ-008 prod  input  N  feedback from the downstream double-wide product register output.
REQ-009 inh  output  W  high-half data to the product register.
REQ-010 inl  output  W  low-half data to the product register.
REQ-011 loadh  output  1  load strobe for the high half.
REQ-012 loadl  output  1  load strobe for the low half.
REQ-013 clr  output  1  active-high clear to the product register; driven directly from a flip-flop.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; product register holds the final a*b.

Function
REQ-016 FSM states: IDLE, CLEAR, LOAD, ADDSHIFT, DONE; encoding is free.
REQ-017 IDLE with start=1 -> CLEAR; a and b are captured into internal registers on the same edge.
REQ-018 CLEAR: clr=1 for exactly one cycle; next state is LOAD.
REQ-019 LOAD: loadl=1, inl=captured b, loadh=0; iteration counter=0; next state is ADDSHIFT.
REQ-020 ADDSHIFT: loadh=loadl=1; sum (W+1 bits) = prod[N-1:W] + (prod[0] ? captured a : 0).
REQ-021 ADDSHIFT: inh = sum[W:1]; inl = {sum[0], prod[W-1:1]}, a one-bit right shift of {sum, prod[W-1:0]}.
REQ-022 ADDSHIFT: stays for exactly W cycles, counter 0..W-1; when counter = W-1, next state is DONE.
REQ-023 DONE: done=1 for one cycle; next state is always IDLE, regardless of start.
REQ-024 In all states other than those named, loadh, loadl and clr are 0; inh/inl are don't-care when their strobe is 0.
REQ-025 Latency: start sampled at edge k -> done=1 in the cycle after edge k+W+2 (W+3 cycles total).
REQ-026 start while busy=1 (including in DONE) is ignored; captured operands do not change.
REQ-027 start held high continuously -> the next operation begins on the IDLE cycle after DONE; back-to-back period is W+4 cycles.
REQ-028 Arithmetic is unsigned; the carry out of the add is kept in inh[W-1] and never lost; the maximum product is (2^W-1)^2.
REQ-029 The prod value after DONE stays stable until the next CLEAR, because the block issues no strobes in IDLE.

Reset
REQ-030 clear_n=0 asynchronously forces IDLE, counter=0, captured a/b=0, and clr=loadh=loadl=busy=done=0.
REQ-031 Reset mid-operation aborts it; no done pulse is generated; the first start after clear_n rises starts a fresh operation.
REQ-032 The block does not clear the product register on reset; the system ties the register clear to clr OR the inverted clear_n.

Verification (bench instantiates the product register with feedback to prod; N=16)
REQ-033 a=8'hFF, b=8'hFF, one-cycle start -> done 11 cycles after the start edge; prod=16'hFE01.
REQ-034 a=8'd13, b=8'd11 -> prod=16'd143; a=8'h00, b=8'hA5 -> prod=16'h0000; a=8'h80, b=8'h02 -> prod=16'h0100.
REQ-035 Start 13*11, then pulse start with a=1, b=1 during ADDSHIFT -> still 143; exactly one done pulse.
REQ-036 Start held high with a=3, b=5 -> done pulses are 12 cycles apart; prod=15 at each done.
REQ-037 clear_n low for one cycle at ADDSHIFT iteration 4 -> busy=0 immediately; no done; a new 7*9 then yields 63.
REQ-038 Random sweep of 1000 operand pairs -> prod equals a*b at every done, and clr is high exactly once per operation.

Source files
------------

// File: rtl/mult_ctrl.sv
// ---------------------------------------------------------------------------
// mult_ctrl -- sequencer for an unsigned shift-and-add multiplier.
//
// The product register sits outside this block. Its output comes back on
// prod, and this block drives the next high/low halves plus load strobes.
// Each operation runs through these states in order:
// CLEAR (zero the register), LOAD (b into low half),
// W x ADDSHIFT (conditional add of a, then shift right), DONE.
//
// Ports
//   clk      rising-edge clock
//   clear_n  async active-low reset
//   start    request a multiply; only looked at in IDLE
//   a, b     W-bit unsigned operands, captured when start is accepted
//   prod     N-bit feedback from the product register
//   inh/inl  next high/low half for the product register
//   loadh/l  load strobes for the high/low halves
//   clr      registered clear to the product register
//   busy     high in every state except IDLE
//   done     one-cycle pulse; the product register holds a*b
// ---------------------------------------------------------------------------
module mult_ctrl #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           clear_n,
    input  logic           start,
    input  logic [N/2-1:0] a,
    input  logic [N/2-1:0] b,
    input  logic [N-1:0]   prod,
    output logic [N/2-1:0] inh,
    output logic [N/2-1:0] inl,
    output logic           loadh,
    output logic           loadl,
    output logic           clr,
    output logic           busy,
    output logic           done
);
    localparam int W  = N / 2;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_ADDSHIFT,
        S_DONE
    } state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_r, b_r;
    logic            clr_q;
    logic [W:0]      sum;

    // State, iteration counter, operand capture, and registered clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            clr_q <= 1'b0;
        end else begin
            state <= nxt;
            // clr is high exactly while the FSM sits in CLEAR.
            clr_q <= (nxt == S_CLEAR);
            if (state == S_IDLE && start) begin
                a_r <= a;
                b_r <= b;
            end
            if (state == S_LOAD)
                cnt <= '0;
            else if (state == S_ADDSHIFT)
                cnt <= cnt + CW'(1);
        end
    end

    // The add keeps its carry in bit W, so that carry ends up in inh[W-1]
    // after the shift.
    always_comb begin
        sum = {1'b0, prod[N-1:W]} + (prod[0] ? {1'b0, a_r} : {(W+1){1'b0}});
    end

    always_comb begin
        nxt   = state;
        inh   = '0;
        inl   = '0;
        loadh = 1'b0;
        loadl = 1'b0;
        case (state)
            S_IDLE:  if (start) nxt = S_CLEAR;
            S_CLEAR: nxt = S_LOAD;
            S_LOAD: begin
                loadl = 1'b1;
                inl   = b_r;
                nxt   = S_ADDSHIFT;
            end
            S_ADDSHIFT: begin
                loadh = 1'b1;
                loadl = 1'b1;
                // {sum, prod[W-1:0]} shifted right by one bit.
                inh   = sum[W:1];
                inl   = {sum[0], prod[W-1:1]};
                if (cnt == CW'(W - 1)) nxt = S_DONE;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    assign clr  = clr_q;
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
